// File: rtl/score_digit_renderer.sv
// Score digit renderer: double-dabble binary-to-BCD converter plus a 2-stage
// per-pixel query pipeline that drives a Symbol glyph ROM. Optional: SCORE_LZ_BLANK_EN.
module score_digit_renderer #(
  parameter logic [9:0] X0 = 10'd64,
  parameter logic [8:0] Y0 = 9'd32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_value,
  input  logic        i_load,
  output logic        o_busy,
  input  logic [9:0]  i_px,
  input  logic [8:0]  i_py,
  input  logic        i_pvalid,
  output logic [4:0]  o_sym_x,
  output logic [5:0]  o_sym_y,
  output logic [3:0]  o_sym_type,
  input  logic        i_sym_dot,
  output logic        o_pixel,
  output logic        o_pvalid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state_q, state_nx;
  logic [15:0]      bin_q;
  logic [19:0]      bcd_q;
  logic [3:0]       iter_q;
  logic [4:0][3:0]  dig_q;

  logic [19:0]      bcd_adj;
  logic [35:0]      dd_shifted;

  // ---------------- conversion FSM ----------------
  always_comb begin
    state_nx = state_q;
    o_busy   = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:  if (i_load) state_nx = ST_SHIFT;
      ST_SHIFT: if (iter_q == 4'd15) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < 5; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    // top bit falls off; max 16-bit input fits in five digits so it is always 0
    dd_shifted = {bcd_adj, bin_q} << 1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_nx;
      case (state_q)
        ST_IDLE: begin
          if (i_load) begin
            bin_q  <= i_value;
            bcd_q  <= '0;
            iter_q <= '0;
          end
        end
        ST_SHIFT: begin
          bcd_q  <= dd_shifted[35:16];
          bin_q  <= dd_shifted[15:0];
          iter_q <= iter_q + 4'd1;
        end
        ST_DONE: dig_q <= bcd_q;
        default: ;
      endcase
    end
  end

  // ---------------- query pipeline, stage 1 ----------------
  logic [9:0] rx;
  logic [8:0] ry;
  logic [4:0] slot;
  logic [4:0] gx;
  logic       in_field;
  logic       blank;
  logic [3:0] digit;

  always_comb begin
    rx       = i_px - X0;
    ry       = i_py - Y0;
    slot     = rx[9:5];
    gx       = rx[4:0];
    in_field = i_pvalid && (i_px >= X0) && (i_py >= Y0) &&
               (slot <= 5'd4) && (gx <= 5'd29) && (ry <= 9'd39);
    // slot 0 is the most significant digit, held in dig_q[4]
    case (slot[2:0])
      3'd0:    digit = dig_q[4];
      3'd1:    digit = dig_q[3];
      3'd2:    digit = dig_q[2];
      3'd3:    digit = dig_q[1];
      default: digit = dig_q[0];
    endcase
  end

`ifdef SCORE_LZ_BLANK_EN
  logic [3:0] lead_zero;
  always_comb begin
    lead_zero[0] = (dig_q[4] == 4'd0);
    lead_zero[1] = lead_zero[0] && (dig_q[3] == 4'd0);
    lead_zero[2] = lead_zero[1] && (dig_q[2] == 4'd0);
    lead_zero[3] = lead_zero[2] && (dig_q[1] == 4'd0);
    blank = 1'b0;
    if (in_field) begin
      case (slot[2:0])
        3'd0:    blank = lead_zero[0];
        3'd1:    blank = lead_zero[1];
        3'd2:    blank = lead_zero[2];
        3'd3:    blank = lead_zero[3];
        default: blank = 1'b0;
      endcase
    end
  end
`else
  always_comb blank = 1'b0;
`endif

  logic s1_valid, s1_in_field, s1_blank;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_sym_x     <= '0;
      o_sym_y     <= '0;
      o_sym_type  <= '0;
      s1_valid    <= 1'b0;
      s1_in_field <= 1'b0;
      s1_blank    <= 1'b0;
    end else begin
      s1_valid    <= i_pvalid;
      s1_in_field <= in_field;
      s1_blank    <= blank;
      if (in_field && !blank) begin
        o_sym_x    <= gx;
        o_sym_y    <= ry[5:0];
        o_sym_type <= digit;
      end else begin
        o_sym_x    <= '0;
        o_sym_y    <= '0;
        o_sym_type <= '0;
      end
    end
  end

  // ---------------- query pipeline, stage 2 ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_pixel  <= 1'b0;
      o_pvalid <= 1'b0;
    end else begin
      o_pixel  <= i_sym_dot & s1_in_field & ~s1_blank;
      o_pvalid <= s1_valid;
    end
  end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Self-checking bench for score_digit_renderer with a stand-in glyph ROM and an
// arithmetic reference model of digits, slot geometry and leading-zero blanking.
module tb_score_digit_renderer;

  localparam logic [9:0] X0 = 10'd64;
  localparam logic [8:0] Y0 = 9'd32;
  localparam int X0I = 64;
  localparam int Y0I = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        busy;
  logic [9:0]  px;
  logic [8:0]  py;
  logic        pvalid;
  logic [4:0]  sym_x;
  logic [5:0]  sym_y;
  logic [3:0]  sym_type;
  logic        sym_dot;
  logic        pixel;
  logic        pvalid_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_val = 0;

  int q_px[$];
  int q_py[$];
  int q_pv[$];

  always #5 clk = ~clk;

  function automatic logic glyph(int t, int x, int y);
    return ((x + 2 * y + 3 * t) % 5) < 2;
  endfunction

  assign sym_dot = glyph(int'(sym_type), int'(sym_x), int'(sym_y));

  score_digit_renderer #(.X0(X0), .Y0(Y0)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_value    (value),
    .i_load     (load),
    .o_busy     (busy),
    .i_px       (px),
    .i_py       (py),
    .i_pvalid   (pvalid),
    .o_sym_x    (sym_x),
    .o_sym_y    (sym_y),
    .o_sym_type (sym_type),
    .i_sym_dot  (sym_dot),
    .o_pixel    (pixel),
    .o_pvalid   (pvalid_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pow10(int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  task automatic model(input int v, input int qx, input int qy, input int qv,
                       output int ex, output int ey, output int et, output int ep);
    int rx, ry, slot, gx;
    bit in, blank;
    rx = qx - X0I;
    ry = qy - Y0I;
    in = (qv != 0) && (qx >= X0I) && (qy >= Y0I);
    slot = in ? rx / 32 : 0;
    gx   = in ? rx % 32 : 0;
    in = in && (slot <= 4) && (gx <= 29) && (ry <= 39);
    blank = 1'b0;
`ifdef SCORE_LZ_BLANK_EN
    if (in && slot < 4 && v < pow10(4 - slot)) blank = 1'b1;
`endif
    if (in && !blank) begin
      ex = gx;
      ey = ry;
      et = (v / pow10(4 - slot)) % 10;
      ep = int'(glyph(et, ex, ey));
    end else begin
      ex = 0; ey = 0; et = 0; ep = 0;
    end
  endtask

  task automatic push(input int qx, input int qy, input int qv);
    q_px.push_back(qx);
    q_py.push_back(qy);
    q_pv.push_back(qv);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(9) < 7)
        push(X0I - 4 + int'($urandom_range(168)), Y0I - 2 + int'($urandom_range(44)),
             int'($urandom_range(7) != 0));
      else
        push(int'($urandom_range(1023)), int'($urandom_range(511)), 1);
    end
  endtask

  task automatic push_slot_sweep(input int row);
    for (int s = 0; s < 5; s++) push(X0I + 32 * s + 7, Y0I + row, 1);
  endtask

  // Streams the queued queries one per cycle; if ld_at >= 0 a load of new_val
  // is issued alongside query ld_at and queries sampled 18+ cycles later see it.
  task automatic run(input int ld_at, input int new_val);
    int n;
    int ex[], ey[], et[], ep[], ev[];
    int v;
    n = q_px.size();
    ex = new[n]; ey = new[n]; et = new[n]; ep = new[n]; ev = new[n];
    if (ld_at >= 0) value = 16'(new_val);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 1 && i - 1 < n) begin
        check("sym_x", 32'(sym_x), 32'(ex[i-1]));
        check("sym_y", 32'(sym_y), 32'(ey[i-1]));
        check("sym_type", 32'(sym_type), 32'(et[i-1]));
      end
      if (i >= 2) begin
        check("pixel", 32'(pixel), 32'(ep[i-2]));
        check("pvalid", 32'(pvalid_out), 32'(ev[i-2]));
      end
      if (i < n) begin
        v = (ld_at >= 0 && i - ld_at >= 18) ? new_val : cur_val;
        model(v, q_px[i], q_py[i], q_pv[i], ex[i], ey[i], et[i], ep[i]);
        ev[i] = q_pv[i];
        px = 10'(q_px[i]);
        py = 9'(q_py[i]);
        pvalid = (q_pv[i] != 0);
      end else begin
        pvalid = 1'b0;
      end
      load = (i == ld_at);
    end
    load = 1'b0;
    if (ld_at >= 0) cur_val = new_val;
    q_px.delete();
    q_py.delete();
    q_pv.delete();
  endtask

  task automatic load_and_count(input int v);
    int cnt;
    @(negedge clk);
    value = 16'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt = 0;
    for (int g = 0; g < 100; g++) begin
      if (!busy) break;
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(cnt), 32'd17);
    cur_val = v;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    load = 1'b1;
    value = 16'd1234;
    px = '0;
    py = '0;
    pvalid = 1'b0;

    // reset with a load held high that must be ignored
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pvalid", 32'(pvalid_out), 32'd0);
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_sym", {17'd0, sym_type, sym_y, sym_x}, 32'd0);
    rst_n = 1'b1;
    load = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    cur_val = 0;
    push(X0I + 4, Y0I + 10, 1);
    push_slot_sweep(10);
    run(-1, 0);

    // full-scale conversion
    load_and_count(65535);
    push_slot_sweep(5);
    push_random(40);
    run(-1, 0);

    // second load while busy is dropped
    @(negedge clk);
    value = 16'd12345;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    value = 16'd999;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_timeout", 32'(cnt < 100), 32'd1);
    repeat (5) @(negedge clk);
    check("no_queued_load", 32'(busy), 32'd0);
    cur_val = 12345;
    push_slot_sweep(0);
    push_slot_sweep(39);
    run(-1, 0);

    // geometry: full row sweep with value 42, then row boundaries
    load_and_count(42);
    for (int x = 0; x < 1024; x++) push(x, Y0I + 20, 1);
    run(-1, 0);
    push(X0I + 100, Y0I + 39, 1);
    push(X0I + 100, Y0I + 40, 1);
    push(X0I + 100, Y0I - 1, 1);
    push(X0I + 159, Y0I + 3, 1);
    push(X0I + 160, Y0I + 3, 1);
    push(X0I - 1, Y0I + 3, 1);
    push(X0I + 130, Y0I + 3, 0);
    push(X0I + 157, Y0I + 0, 1);
    run(-1, 0);

    // zero value: leading-zero behaviour
    load_and_count(0);
    push_slot_sweep(12);
    run(-1, 0);

    // random values
    for (int r = 0; r < 6; r++) begin
      load_and_count(int'($urandom_range(65535)));
      push_random(60);
      run(-1, 0);
    end

    // queries streaming across a conversion: old digits until the DONE edge
    push_random(10);
    for (int i = 0; i < 20; i++) push(X0I + 32 * (i % 5) + 3 + i, Y0I + 8, 1);
    run(2, int'($urandom_range(65535)));

    // reset mid-conversion
    @(negedge clk);
    value = 16'd500;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    load = 1'b1;
    value = 16'd3;
    repeat (2) @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    load = 1'b0;
    @(negedge clk);
    check("midrst_idle", 32'(busy), 32'd0);
    cur_val = 0;
    push_slot_sweep(15);
    run(-1, 0);
    load_and_count(7);
    push_slot_sweep(15);
    push_random(20);
    run(-1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
